// File: rtl/fnd_scan_controller_pkg.sv
// fnd_pkg: shared constants for the FND scan controller.
// Active-low 7-segment codes in {dp,g,f,e,d,c,b,a} order, the dp bit index,
// and the digit count of the multiplexed display.
package fnd_pkg;
    localparam int DIGITS = 4;
    localparam int DP_BIT = 7;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
endpackage

// File: rtl/fnd_scan_controller_digit_decoder.sv
// fnd_digit_decoder: combinational BCD digit to active-low segment code.
// Ports: i_digit (0..9), i_dash (show '-'), i_blank (show nothing),
//        o_seg {dp,g,f,e,d,c,b,a} active-low, dp always off.
// Dash takes priority over blank.
module fnd_digit_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_dash,
    input  logic       i_blank,
    output logic [7:0] o_seg
);
    logic [7:0] num;
    always_comb begin
        num = SEG_BLANK;
        case (i_digit)
            4'd0: num = SEG_0;
            4'd1: num = SEG_1;
            4'd2: num = SEG_2;
            4'd3: num = SEG_3;
            4'd4: num = SEG_4;
            4'd5: num = SEG_5;
            4'd6: num = SEG_6;
            4'd7: num = SEG_7;
            4'd8: num = SEG_8;
            4'd9: num = SEG_9;
            default: num = SEG_BLANK;
        endcase
        o_seg = i_dash ? SEG_DASH : (i_blank ? SEG_BLANK : num);
    end
endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: 4-digit multiplexed 7-segment driver for a packed time bus.
// Ports: clk, rst (sync, active-low), i_time_data {hour,min,sec,msec},
//        i_disp_sel (0 = sec.msec, 1 = hour.min),
//        o_fnd_com (active-low digit enables), o_fnd_data (active-low segments).
// Optional: define FND_LEADING_ZERO_BLANK_EN to blank a leading zero on digit 3.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int F_CLK   = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_time_data,
    input  logic        i_disp_sel,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_data
);
    localparam int SCAN_DIV = F_CLK / SCAN_HZ;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int PW = $clog2(DIGITS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [31:0]   snap_time_q, snap_time_d;
    logic          snap_sel_q, snap_sel_d;
    logic [3:0]    com_q, com_d;
    logic [7:0]    data_q, data_d;

    logic          scan, frame_start, sel, oor, dp_on, blank;
    logic [31:0]   tim;
    logic [7:0]    field;
    logic [3:0]    digit;
    logic [7:0]    seg;

    fnd_digit_decoder u_dec (
        .i_digit (digit),
        .i_dash  (oor),
        .i_blank (blank),
        .o_seg   (seg)
    );

    always_comb begin
        scan        = cnt_q == CW'(SCAN_DIV - 1);
        frame_start = scan && ptr_q == '0;
        // Digit 0 decodes straight from the input being captured this edge.
        tim         = frame_start ? i_time_data : snap_time_q;
        sel         = frame_start ? i_disp_sel : snap_sel_q;
        field       = ptr_q[1] ? (sel ? tim[31:24] : tim[15:8])
                               : (sel ? tim[23:16] : tim[7:0]);
        oor         = field > 8'd99;
        digit       = ptr_q[0] ? 4'(field / 8'd10) : 4'(field % 8'd10);
`ifdef FND_LEADING_ZERO_BLANK_EN
        blank       = ptr_q == PW'(3) && digit == 4'd0;
`else
        blank       = 1'b0;
`endif
        // Half-second dp blink keyed to the snapshot's msec field.
        dp_on       = ptr_q == PW'(2) && tim[7:0] < 8'd50 && !oor;
        cnt_d       = scan ? '0 : cnt_q + 1'b1;
        ptr_d       = scan ? ptr_q + 1'b1 : ptr_q;
        snap_time_d = frame_start ? i_time_data : snap_time_q;
        snap_sel_d  = frame_start ? i_disp_sel : snap_sel_q;
        com_d       = scan ? ~(4'b0001 << ptr_q) : com_q;
        data_d      = scan ? (dp_on ? seg & ~(8'h01 << DP_BIT) : seg) : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            ptr_q       <= '0;
            snap_time_q <= '0;
            snap_sel_q  <= 1'b0;
            com_q       <= 4'hF;
            data_q      <= SEG_BLANK;
        end else begin
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            snap_time_q <= snap_time_d;
            snap_sel_q  <= snap_sel_d;
            com_q       <= com_d;
            data_q      <= data_d;
        end
    end

    assign o_fnd_com  = com_q;
    assign o_fnd_data = data_q;
endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: directed and randomized checks against a frame-level model.
module tb_fnd_scan_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_time_data = 32'h0C223807;
    logic        i_disp_sel = 1'b0;
    logic [3:0]  o_fnd_com;
    logic [7:0]  o_fnd_data;

    int checks = 0;
    int errors = 0;

    fnd_scan_controller #(.F_CLK(400), .SCAN_HZ(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_time_data(i_time_data),
        .i_disp_sel (i_disp_sel),
        .o_fnd_com  (o_fnd_com),
        .o_fnd_data (o_fnd_data)
    );

    always #5 clk = ~clk;

    logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [7:0] ref_seg(input logic [31:0] t, input logic s, input int k);
        int v, d;
        logic [7:0] r;
        v = (k < 2) ? (s ? int'(t[23:16]) : int'(t[7:0])) : (s ? int'(t[31:24]) : int'(t[15:8]));
        if (v > 99) return 8'hBF;
        d = (k % 2 == 1) ? v / 10 : v % 10;
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (k == 3 && d == 0) return 8'hFF;
`endif
        r = lut[d];
        if (k == 2 && t[7:0] < 50) r[7] = 1'b0;
        return r;
    endfunction

    // Model: cycles since reset release; every 4th cycle shows the next digit.
    int          cyc = 0;
    logic [31:0] m_time = '0;
    logic        m_sel = 1'b0;
    logic [3:0]  exp_com = 4'hF;
    logic [7:0]  exp_data = 8'hFF;

    always @(posedge clk) begin
        if (!rst) begin
            cyc = 0; m_time = '0; m_sel = 1'b0; exp_com = 4'hF; exp_data = 8'hFF;
        end else begin
            if (cyc % 4 == 3) begin
                int k;
                k = (cyc / 4) % 4;
                if (k == 0) begin
                    m_time = i_time_data;
                    m_sel = i_disp_sel;
                end
                exp_com = ~(4'b0001 << k);
                exp_data = ref_seg(m_time, m_sel, k);
            end
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("model_com", {4'h0, o_fnd_com}, {4'h0, exp_com});
        check("model_seg", o_fnd_data, exp_data);
    endtask

    // Advance to the next digit (frame-aligned) and check it against constants.
    task automatic digit_is(input string tag, input logic [3:0] com, input logic [7:0] seg);
        repeat (4) step();
        check({tag, "_com"}, {4'h0, o_fnd_com}, {4'h0, com});
        check({tag, "_seg"}, o_fnd_data, seg);
    endtask

    logic [3:0] coms [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        repeat (10) begin
            step();
            check("rst_com", {4'h0, o_fnd_com}, 8'h0F);
            check("rst_seg", o_fnd_data, 8'hFF);
        end
        rst = 1'b1;
        repeat (3) step();
        check("pre_scan", o_fnd_data, 8'hFF);
        // First frame: the digit_is loop starts one step early to land on cycle 3.
        step();
        check("f1_d0", o_fnd_data, 8'hF8);
        check("f1_c0", {4'h0, o_fnd_com}, 8'h0E);
        digit_is("f1_d1", 4'hD, 8'hC0);
        digit_is("f1_d2", 4'hB, 8'h02);
        digit_is("f1_d3", 4'h7, 8'h92);
        i_disp_sel = 1'b1;
        digit_is("f2_d0", 4'hE, 8'h99);
        digit_is("f2_d1", 4'hD, 8'hB0);
        digit_is("f2_d2", 4'hB, 8'h24);
        digit_is("f2_d3", 4'h7, 8'hF9);
        i_disp_sel = 1'b0;
        i_time_data = 32'h0C22384B;
        digit_is("f3_d0", 4'hE, 8'h92);
        digit_is("f3_d1", 4'hD, 8'hF8);
        digit_is("f3_d2", 4'hB, 8'h82);
        digit_is("f3_d3", 4'h7, 8'h92);
        i_time_data = 32'h0C223807;
        digit_is("f4_d0", 4'hE, 8'hF8);
        digit_is("f4_d1", 4'hD, 8'hC0);
        i_time_data = 32'h01020304;
        i_disp_sel = 1'b1;
        digit_is("f4_d2_old", 4'hB, 8'h02);
        digit_is("f4_d3_old", 4'h7, 8'h92);
        digit_is("f5_d0_new", 4'hE, 8'hA4);
        digit_is("f5_d1_new", 4'hD, 8'hC0);
        digit_is("f5_d2_new", 4'hB, 8'h79);
        rst = 1'b0;
        step();
        check("midrst_com", {4'h0, o_fnd_com}, 8'h0F);
        check("midrst_seg", o_fnd_data, 8'hFF);
        rst = 1'b1;
        i_time_data = 32'h00007B0A;
        i_disp_sel = 1'b0;
        repeat (3) step();
        step();
        check("restart_com", {4'h0, o_fnd_com}, 8'h0E);
        check("oor_d0", o_fnd_data, 8'hC0);
        digit_is("oor_d1", 4'hD, 8'hF9);
        digit_is("oor_d2", 4'hB, 8'hBF);
        digit_is("oor_d3", 4'h7, 8'hBF);
        i_time_data = 32'h0000050A;
        digit_is("lz_d0", 4'hE, 8'hC0);
        digit_is("lz_d1", 4'hD, 8'hF9);
        digit_is("lz_d2", 4'hB, 8'h12);
`ifdef FND_LEADING_ZERO_BLANK_EN
        digit_is("lz_d3", 4'h7, 8'hFF);
`else
        digit_is("lz_d3", 4'h7, 8'hC0);
`endif
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                i_time_data = {1'b0, 7'($urandom_range(0, 127)), 1'b0, 7'($urandom_range(0, 127)),
                               1'b0, 7'($urandom_range(0, 127)), 1'b0, 7'($urandom_range(0, 127))};
                i_disp_sel = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
